// File: rtl/uart_rx.sv
// 8N1 UART receiver with ready/valid byte output, frame-error and overrun pulses.
// Define UART_RX_FIFO_EN to replace the single holding register with a 4-entry FIFO.
module uart_rx #(
    parameter int unsigned CLOCK_HZ = 50000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       serial_in,
    input  logic       rx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       frame_error,
    output logic       overrun
);

    localparam int unsigned DIV = CLOCK_HZ / BAUD;
    localparam int unsigned CW  = $clog2(DIV);
    localparam logic [CW-1:0] CntFull = CW'(DIV - 1);
    localparam logic [CW-1:0] CntHalf = CW'(DIV / 2 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } state_e;

    logic [1:0]    sync_q;
    logic          rx_s;
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          frame_error_q;
    logic          overrun_q;
    logic          wr_en;

    assign rx_s = sync_q[1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], serial_in};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            frame_error_q <= 1'b0;
        end else begin
            frame_error_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_q <= StStart;
                        cnt_q   <= CntHalf;
                    end
                end
                StStart: begin
                    if (cnt_q == '0) begin
                        // A line that is high again at mid start bit was a glitch
                        if (rx_s) begin
                            state_q <= StIdle;
                        end else begin
                            state_q <= StData;
                            cnt_q   <= CntFull;
                            idx_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                StData: begin
                    if (cnt_q == '0) begin
                        shift_q[idx_q] <= rx_s;
                        cnt_q          <= CntFull;
                        if (idx_q == 3'd7) begin
                            state_q <= StStop;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                StStop: begin
                    if (cnt_q == '0) begin
                        if (rx_s) begin
                            state_q <= StIdle;
                        end else begin
                            frame_error_q <= 1'b1;
                            state_q       <= StWaitIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                StWaitIdle: begin
                    if (rx_s) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Good stop bit sampled this cycle: hand the byte to the output buffer
    assign wr_en = (state_q == StStop) && (cnt_q == '0) && rx_s;

`ifdef UART_RX_FIFO_EN
    logic [7:0] mem_q [4];
    logic [1:0] wptr_q;
    logic [1:0] rptr_q;
    logic [2:0] fifo_cnt_q;
    logic       rd;
    logic       full;
    logic       wr_ok;

    assign rd    = (fifo_cnt_q != 3'd0) && rx_ready;
    assign full  = (fifo_cnt_q == 3'd4);
    assign wr_ok = wr_en && (!full || rd);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q     <= '0;
            rptr_q     <= '0;
            fifo_cnt_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= wr_en && full && !rd;
            if (wr_ok) begin
                mem_q[wptr_q] <= shift_q;
                wptr_q        <= wptr_q + 2'd1;
            end
            if (rd) begin
                rptr_q <= rptr_q + 2'd1;
            end
            case ({wr_ok, rd})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 3'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 3'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    assign rx_valid = (fifo_cnt_q != 3'd0);
    assign rx_data  = mem_q[rptr_q];
`else
    logic       valid_q;
    logic [7:0] data_q;
    logic       xfer;

    assign xfer = valid_q && rx_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (xfer) begin
                valid_q <= 1'b0;
            end
            if (wr_en) begin
                if (!valid_q || xfer) begin
                    valid_q <= 1'b1;
                    data_q  <= shift_q;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign rx_valid = valid_q;
    assign rx_data  = data_q;
`endif

    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLOCK_HZ=16, BAUD=1 (16 clocks per bit).
module tb_uart_rx;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       serial_in;
    logic       rx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       frame_error;
    logic       overrun;

    uart_rx #(
        .CLOCK_HZ(16),
        .BAUD    (1)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .serial_in  (serial_in),
        .rx_ready   (rx_ready),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .frame_error(frame_error),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: observes the bus mid-cycle; only this process writes these
    logic [7:0] got[$];
    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    int         ovr_cnt   = 0;
    int         hold_viol = 0;
    int         rise_cyc  = 0;
    int         width     = 0;
    logic       prev_valid = 1'b0;
    logic       hold_pend  = 1'b0;
    logic [7:0] hold_data  = 8'h00;

    always @(negedge clock) begin
        if (hold_pend && reset_n && (!rx_valid || rx_data !== hold_data)) hold_viol++;
        hold_pend = rx_valid && !rx_ready && reset_n;
        hold_data = rx_data;
        if (rx_valid && !prev_valid) begin
            valid_cnt++;
            rise_cyc = cyc;
            width    = 0;
        end
        if (rx_valid) width++;
        if (rx_valid && rx_ready) got.push_back(rx_data);
        if (frame_error) ferr_cnt++;
        if (overrun) ovr_cnt++;
        prev_valid = rx_valid;
    end

    int errors = 0;
    int checks = 0;
    int fall_cyc = 0;
    int b_v, b_f, b_o, b_g;
    logic stop_rdy;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic hold(input logic v, input int n);
        serial_in = v;
        idle(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input int stop_low);
        fall_cyc = cyc;
        hold(1'b0, 16);
        for (int i = 0; i < 8; i++) hold(d[i], 16);
        if (stop_low > 0) hold(1'b0, stop_low);
        hold(1'b1, 16);
    endtask

    task automatic snap();
        b_v = valid_cnt;
        b_f = ferr_cnt;
        b_o = ovr_cnt;
        b_g = got.size();
    endtask

    // Checks one accepted byte: value, 155-cycle latency (+/-1), one-cycle valid
    task automatic check_byte(input string name, input logic [7:0] d);
        int lat;
        check({name, "_count"}, got.size() - b_g, 1);
        if (got.size() > b_g) check({name, "_data"}, got[b_g], d);
        lat = rise_cyc - fall_cyc;
        check({name, "_latency_ok"}, (lat >= 154 && lat <= 156) ? 1 : 0, 1);
        check({name, "_width"}, width, 1);
        check({name, "_no_err"}, (ferr_cnt - b_f) + (ovr_cnt - b_o), 0);
    endtask

    typedef struct {
        logic [7:0] data;
        int         stop_low;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8'h55, 0, 1, 0};
        vecs[1] = '{8'h00, 0, 1, 0};
        vecs[2] = '{8'hFF, 0, 1, 0};
        vecs[3] = '{8'h80, 0, 1, 0};
        vecs[4] = '{8'h01, 0, 1, 0};
        vecs[5] = '{8'hA3, 40, 0, 1};
        vecs[6] = '{8'h3C, 0, 1, 0};

        reset_n   = 1'b0;
        serial_in = 1'b1;
        rx_ready  = 1'b1;
        stop_rdy  = 1'b0;
        idle(3);
        check("reset_valid", rx_valid, 0);
        check("reset_data", rx_data, 0);
        check("reset_ferr", frame_error, 0);
        check("reset_ovr", overrun, 0);
        reset_n = 1'b1;
        idle(5);

        for (int i = 0; i < 7; i++) begin
            snap();
            send_frame(vecs[i].data, vecs[i].stop_low);
            idle(24);
            check($sformatf("vec%0d_valid", i), valid_cnt - b_v, vecs[i].exp_valid);
            check($sformatf("vec%0d_ferr", i), ferr_cnt - b_f, vecs[i].exp_ferr);
            if (vecs[i].exp_valid == 1) check_byte($sformatf("vec%0d", i), vecs[i].data);
        end

        // Short glitch: no output, and the receiver must still catch the next frame
        snap();
        hold(1'b0, 4);
        hold(1'b1, 40);
        check("glitch_valid", valid_cnt - b_v, 0);
        check("glitch_ferr", ferr_cnt - b_f, 0);
        snap();
        send_frame(8'h96, 0);
        idle(24);
        check_byte("after_glitch", 8'h96);

        // Consumer stalled across two frames
        snap();
        rx_ready = 1'b0;
        send_frame(8'h11, 0);
        send_frame(8'h22, 0);
        idle(20);
        check("stall_no_xfer", got.size() - b_g, 0);
        check("stall_valid", rx_valid, 1);
        check("stall_data", rx_data, 8'h11);
`ifdef UART_RX_FIFO_EN
        check("stall_ovr", ovr_cnt - b_o, 0);
        rx_ready = 1'b1;
        idle(6);
        check("stall_drain_cnt", got.size() - b_g, 2);
        if (got.size() >= b_g + 2) begin
            check("stall_drain0", got[b_g], 8'h11);
            check("stall_drain1", got[b_g+1], 8'h22);
        end

        snap();
        rx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_frame(8'h41 + 8'(i), 0);
            if (i == 3) check("fifo_full_no_ovr", ovr_cnt - b_o, 0);
        end
        idle(10);
        check("fifo_ovr_count", ovr_cnt - b_o, 2);
        rx_ready = 1'b1;
        idle(8);
        check("fifo_drain_cnt", got.size() - b_g, 4);
        for (int i = 0; i < 4; i++)
            if (got.size() > b_g + i) check($sformatf("fifo_drain%0d", i), got[b_g+i], 8'h41 + 8'(i));
`else
        check("stall_ovr", ovr_cnt - b_o, 1);
        rx_ready = 1'b1;
        idle(6);
        check("stall_drain_cnt", got.size() - b_g, 1);
        if (got.size() > b_g) check("stall_drain0", got[b_g], 8'h11);
`endif

        // Reset in the middle of data bit 4; the rest of the frame is all ones
        snap();
        fork
            send_frame(8'hF5, 0);
            begin
                repeat (88) @(posedge clock);
                #2 reset_n = 1'b0;
                #1;
                check("midrst_valid", rx_valid, 0);
                check("midrst_data", rx_data, 0);
                check("midrst_ferr", frame_error, 0);
                check("midrst_ovr", overrun, 0);
                @(posedge clock);
                #1 reset_n = 1'b1;
            end
        join
        idle(30);
        check("midrst_no_byte", valid_cnt - b_v, 0);
        check("midrst_no_ferr", ferr_cnt - b_f, 0);
        snap();
        send_frame(8'h7E, 0);
        idle(24);
        check_byte("after_rst", 8'h7E);

        // Random bytes under a randomly stalling consumer; reference is an ordered queue
        snap();
        exp_q.delete();
        fork
            begin
                while (!stop_rdy) begin
                    @(posedge clock);
                    #1 rx_ready = 1'($urandom_range(0, 1));
                end
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    logic [7:0] d;
                    d = 8'($urandom);
                    exp_q.push_back(d);
                    send_frame(d, 0);
                    idle($urandom_range(0, 20));
                end
                stop_rdy = 1'b1;
            end
        join
        rx_ready = 1'b1;
        idle(30);
        check("rand_count", got.size() - b_g, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (got.size() > b_g + i) check($sformatf("rand%0d", i), got[b_g+i], exp_q[i]);
        check("rand_ferr", ferr_cnt - b_f, 0);
        check("rand_ovr", ovr_cnt - b_o, 0);

        check("hold_stable", hold_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCK_HZ, default 50000000, meaning the clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the line bit rate.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port serial_in, input, 1 bit: the asynchronous serial line, idle high.
REQ-006 SHALL have port rx_ready, input, 1 bit: the consumer accepts a byte.
REQ-007 SHALL have port rx_valid, output, 1 bit: a received byte is available.
REQ-008 SHALL have port rx_data, output, 8 bits: the received byte.
REQ-009 SHALL have port frame_error, output, 1 bit: one-cycle pulse when the stop bit samples low.
REQ-010 SHALL have port overrun, output, 1 bit: one-cycle pulse when a good byte is dropped.

Function
REQ-011 SHALL compute DIV = CLOCK_HZ/BAUD (integer truncation, DIV >= 4) and use a bit counter wide enough to hold DIV-1.
REQ-012 SHALL pass serial_in through a 2-flop synchronizer (reset value 1) and use only the synchronized value.
REQ-013 SHALL implement the states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-014 IDLE: synchronized line 0 -> START with the counter loaded to DIV/2-1.
REQ-015 START: at counter 0, sample the line: 1 -> IDLE (false start, no output); 0 -> DATA with the counter at DIV-1 and the bit index at 0.
REQ-016 DATA: at each counter expiry, shift the sample into bit[index], LSB first, and reload DIV-1; after bit 7 -> STOP.
REQ-017 STOP: at counter expiry, sample 1 -> deliver the byte and go to IDLE; sample 0 -> pulse frame_error, discard the byte and go to WAIT_IDLE.
REQ-018 WAIT_IDLE: stay until the synchronized line is 1, then go to IDLE (break handling: no repeated errors).
REQ-019 A delivered byte SHALL appear on rx_valid/rx_data on the cycle after the stop-bit sample.
REQ-020 Handshake: a transfer occurs when rx_valid and rx_ready are both 1 on a clock edge; rx_valid and rx_data SHALL stay stable until the transfer.
REQ-021 Delivery when the output buffer is full and no transfer occurs on that edge SHALL drop the new byte, keep the old one and pulse overrun.
REQ-022 Delivery on the same edge as a transfer from a full buffer SHALL be accepted without overrun.
REQ-023 rx_ready SHALL not affect the receive state machine timing.

Reset
REQ-024 reset_n low SHALL asynchronously force IDLE, synchronizer flops = 1, counters = 0, rx_valid = 0, rx_data = 0, frame_error = 0 and overrun = 0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; after release, reception SHALL restart only on a new falling edge seen in IDLE.

Configuration
REQ-026 Macro UART_RX_FIFO_EN defined: the output buffer SHALL be a 4-entry FIFO; rx_valid = not empty; overrun occurs only when the FIFO is full; a write and a read on the same edge while full SHALL both succeed.
REQ-027 Macro UART_RX_FIFO_EN undefined: the output buffer SHALL be a single holding register with the behaviour of REQ-021/REQ-022.

Verification (CLOCK_HZ=16, BAUD=1, DIV=16)
REQ-028 Frame 0x55 with rx_ready=1 -> rx_valid=1 and rx_data=0x55 for one cycle, 1+16*9+8+2 cycles after the falling edge (+/-1 for synchronizer alignment); no error pulses.
REQ-029 Low pulse of 4 cycles on an idle line -> no rx_valid and no frame_error; the state returns to IDLE.
REQ-030 Frame 0xA3 with the stop bit held low for 40 cycles -> one frame_error pulse, no rx_valid; a following 0x3C frame is received correctly.
REQ-031 rx_ready=0 and frames 0x11 then 0x22 -> without FIFO: rx_data stays 0x11 and overrun pulses once; with FIFO: both bytes are delivered in order when rx_ready rises.
REQ-032 rx_ready=0 and six frames with the FIFO enabled -> the first four bytes are delivered in order and overrun pulses on frames 5 and 6.
REQ-033 reset_n pulsed low during bit 4 of a frame -> outputs go to 0 immediately; the remaining bits produce no byte; the next full frame 0x7E is received.
